mm_bus_arbiter: RTL and testbench

- Shares the processor's external memory-mapped bus with one auxiliary master (debug loader / DMA-style requester).
- Sits between the CPU's memory-mapped port (`mm_re`, `mm_we`, `addr`, `wdata`, `rdata`) and the peripheral bus.
- The CPU samples read data in the same cycle it issues the read and cannot stall, so the CPU always has absolute, zero-latency priority.
- The auxiliary master is served through a pulse-request / ack handshake in cycles where the CPU is not using the bus.

---
 rtl/mm_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mm_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bus_arbiter.sv
// Shares the peripheral bus between the CPU (absolute, zero-latency priority)
// and one auxiliary master served by a pulse-request / ack handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no aux transaction; waiting for an aux_req pulse
// S_ISSUE  | aux request latched; drives the bus on the first CPU-free cycle
// S_DONE   | aux access finished; aux_ack with aux_err = 0
// S_REJECT | request targeted internal DM space; aux_ack with aux_err = 1
module mm_bus_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_re,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_busy,
  output logic          aux_ack,
  output logic          aux_err,
  output logic [DW-1:0] aux_rdata,
  output logic [7:0]    aux_wait_cnt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_re,
  output logic          bus_we,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DONE   = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    wait_q, wait_d;

  logic cpu_act;
  logic sel_aux;

  assign cpu_act = cpu_re | cpu_we;
  assign sel_aux = (state_q == S_ISSUE) & ~cpu_act;

  // CPU path stays purely combinational; aux only fills CPU-free cycles.
  assign bus_addr  = sel_aux ? addr_q : cpu_addr;
  assign bus_wdata = sel_aux ? wdata_q : cpu_wdata;
  assign bus_re    = cpu_re | (sel_aux & ~we_q);
  assign bus_we    = cpu_we | (sel_aux & we_q);
  assign cpu_rdata = bus_rdata;

  assign aux_busy     = (state_q != S_IDLE);
  assign aux_ack      = (state_q == S_DONE) | (state_q == S_REJECT);
  assign aux_err      = (state_q == S_REJECT);
  assign aux_rdata    = rdata_q;
  assign aux_wait_cnt = wait_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (aux_req) begin
          addr_d  = aux_addr;
          wdata_d = aux_wdata;
          we_d    = aux_we;
          // Top three address bits all zero select the core's internal DM.
          if (aux_addr[AW-1 -: 3] == 3'b000) begin
            state_d = S_REJECT;
          end else begin
            wait_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cpu_act) begin
          if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
        end else begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mm_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_re;
  logic          cpu_we;
  logic [DW-1:0] cpu_rdata;
  logic          aux_req;
  logic          aux_we;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic          aux_busy;
  logic          aux_ack;
  logic          aux_err;
  logic [DW-1:0] aux_rdata;
  logic [7:0]    aux_wait_cnt;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_re;
  logic          bus_we;
  logic [DW-1:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int acks;
  logic strobe_seen;
  logic overlap_seen;

  mm_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .aux_req      (aux_req),
    .aux_we       (aux_we),
    .aux_addr     (aux_addr),
    .aux_wdata    (aux_wdata),
    .aux_busy     (aux_busy),
    .aux_ack      (aux_ack),
    .aux_err      (aux_err),
    .aux_rdata    (aux_rdata),
    .aux_wait_cnt (aux_wait_cnt),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_re       (bus_re),
    .bus_we       (bus_we),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    aux_req   = 1'b1;
    aux_we    = we;
    aux_addr  = a;
    aux_wdata = d;
  endtask

  task automatic unreq();
    aux_req   = 1'b0;
    aux_we    = 1'b0;
    aux_addr  = '0;
    aux_wdata = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    bus_rdata = '0;
    unreq();
    #3;
    chk("rst_busy",  aux_busy, 0);
    chk("rst_ack",   aux_ack, 0);
    chk("rst_err",   aux_err, 0);
    chk("rst_rdata", aux_rdata, 0);
    chk("rst_wait",  aux_wait_cnt, 0);
    chk("rst_bus",   {bus_re, bus_we, bus_addr, bus_wdata}, 0);
    #4 rst_n = 1'b1;

    // CPU-only combinational path
    tick();
    cpu_re = 1'b1; cpu_addr = 16'hC004; bus_rdata = 16'h1234;
    #1;
    chk("cpu_rd_re",    bus_re, 1);
    chk("cpu_rd_we",    bus_we, 0);
    chk("cpu_rd_addr",  bus_addr, 16'hC004);
    chk("cpu_rd_rdata", cpu_rdata, 16'h1234);
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_wdata = 16'h00FF;
    #1;
    chk("cpu_wr_we",    bus_we, 1);
    chk("cpu_wr_re",    bus_re, 0);
    chk("cpu_wr_wdata", bus_wdata, 16'h00FF);
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Aux read on an idle bus
    tick();
    req(1'b0, 16'hC000, 16'h0000); bus_rdata = 16'hBEEF;
    sample();
    chk("rd_c0_busy", aux_busy, 0);
    tick(); unreq();
    sample();
    chk("rd_c1_re",   bus_re, 1);
    chk("rd_c1_we",   bus_we, 0);
    chk("rd_c1_addr", bus_addr, 16'hC000);
    chk("rd_c1_busy", aux_busy, 1);
    chk("rd_c1_ack",  aux_ack, 0);
    tick();
    sample();
    chk("rd_c2_ack",   aux_ack, 1);
    chk("rd_c2_err",   aux_err, 0);
    chk("rd_c2_rdata", aux_rdata, 16'hBEEF);
    chk("rd_c2_wait",  aux_wait_cnt, 0);
    chk("rd_c2_busy",  aux_busy, 1);
    chk("rd_c2_re",    bus_re, 0);
    tick();
    sample();
    chk("rd_c3_ack",   aux_ack, 0);
    chk("rd_c3_busy",  aux_busy, 0);
    chk("rd_c3_rdata", aux_rdata, 16'hBEEF);

    // Aux write blocked by three CPU read cycles
    tick();
    req(1'b1, 16'hE000, 16'h5A5A);
    tick(); unreq();
    cpu_re = 1'b1; cpu_addr = 16'hC010; bus_rdata = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("ct_cpu_we",   bus_we, 0);
      chk("ct_cpu_addr", bus_addr, 16'hC010);
      tick();
    end
    cpu_re = 1'b0; cpu_addr = '0;
    sample();
    chk("ct_aux_we",    bus_we, 1);
    chk("ct_aux_re",    bus_re, 0);
    chk("ct_aux_addr",  bus_addr, 16'hE000);
    chk("ct_aux_wdata", bus_wdata, 16'h5A5A);
    chk("ct_aux_wait",  aux_wait_cnt, 3);
    tick();
    sample();
    chk("ct_ack",   aux_ack, 1);
    chk("ct_err",   aux_err, 0);
    chk("ct_wait",  aux_wait_cnt, 3);
    chk("ct_rdata", aux_rdata, 16'hBEEF);

    // Reject of internal DM address
    tick();
    req(1'b1, 16'h1000, 16'hFFFF);
    strobe_seen = 1'b0;
    sample();
    strobe_seen |= bus_re | bus_we;
    tick(); unreq();
    sample();
    strobe_seen |= bus_re | bus_we;
    chk("rj_ack",  aux_ack, 1);
    chk("rj_err",  aux_err, 1);
    chk("rj_busy", aux_busy, 1);
    tick();
    sample();
    strobe_seen |= bus_re | bus_we;
    chk("rj_idle",   aux_busy, 0);
    chk("rj_strobe", strobe_seen, 0);
    chk("rj_rdata",  aux_rdata, 16'hBEEF);

    // Request while busy is dropped
    tick();
    req(1'b0, 16'hC100, 16'h0000); bus_rdata = 16'h1111;
    tick();
    req(1'b0, 16'hC200, 16'h0000);
    cpu_re = 1'b1;
    acks = 0;
    overlap_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (aux_ack) acks++;
      if (cpu_re && bus_addr != cpu_addr) overlap_seen = 1'b1;
      tick();
      unreq();
      if (i == 1) cpu_re = 1'b0;
    end
    chk("drop_acks",    acks, 1);
    chk("drop_rdata",   aux_rdata, 16'h1111);
    chk("drop_wait",    aux_wait_cnt, 2);
    chk("drop_overlap", overlap_seen, 0);

    // Wait counter saturation
    req(1'b1, 16'hC300, 16'hAAAA);
    tick(); unreq();
    cpu_re = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    sample();
    chk("sat_wait", aux_wait_cnt, 255);
    chk("sat_busy", aux_busy, 1);
    chk("sat_we",   bus_we, 0);
    tick();
    cpu_re = 1'b0;
    sample();
    chk("sat_bus_we",   bus_we, 1);
    chk("sat_bus_addr", bus_addr, 16'hC300);
    tick();
    sample();
    chk("sat_ack",     aux_ack, 1);
    chk("sat_wait_hd", aux_wait_cnt, 255);
    tick();

    // Reset while in ISSUE
    req(1'b0, 16'hC400, 16'h0000); bus_rdata = 16'h3333;
    tick(); unreq();
    cpu_re = 1'b1;
    sample();
    chk("rs_pre_busy", aux_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_busy",  aux_busy, 0);
    chk("rs_ack",   aux_ack, 0);
    chk("rs_rdata", aux_rdata, 0);
    chk("rs_wait",  aux_wait_cnt, 0);
    chk("rs_re",    bus_re, 1);
    cpu_re = 1'b0;
    #1;
    chk("rs_bus", {bus_re, bus_we, bus_addr, bus_wdata}, 0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      if (aux_ack) acks++;
    end
    chk("rs_noack", acks, 0);
    #2 rst_n = 1'b1;

    tick();
    req(1'b0, 16'hC500, 16'h0000); bus_rdata = 16'h2222;
    tick(); unreq();
    sample();
    chk("pr_re",   bus_re, 1);
    chk("pr_addr", bus_addr, 16'hC500);
    tick();
    sample();
    chk("pr_ack",   aux_ack, 1);
    chk("pr_err",   aux_err, 0);
    chk("pr_rdata", aux_rdata, 16'h2222);
    chk("pr_wait",  aux_wait_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
